// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
// Used by both the receiver and the transmitter side of the link.
package uart_pkg;

    // FSM state encoding, 3 bits wide.
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BRK   = 3'd4;

    // 8N1 frame constants.
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Busy means anything other than waiting for a start edge.
    function automatic logic uart_is_busy(input uart_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Both stages reset to RESET_VAL so an idle-high line does not look like a
// falling edge right after reset.
module uart_rx_sync #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: first stage captures the raw input, second stage the first.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchroniser stages with asynchronous reset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_receiver_enable.sv
// UART receiver, 8N1, LSB first, idle-high line, OVERSAMPLE x baud clock.
// Delivers each good byte on DATA with a one-cycle Valid strobe, flags a
// stop bit sampled low with a one-cycle Frame_Err strobe, and reports frame
// activity on Status_R. En is active-low (1 disables and forces IDLE).
//
// Handshake: there is no back-pressure. Valid is a single-cycle strobe that
// coincides with DATA taking the new byte; the host must capture DATA on that
// cycle or later (DATA holds until the next good frame). Frame_Err is a
// single-cycle strobe and is never high together with Valid.
module uart_receiver_enable
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 Div_CLK,
    input  logic                 RST,
    input  logic                 En,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 Valid,
    output logic                 Frame_Err,
    output logic                 Status_R,
    output logic [2:0]           dbg_state
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    // Last tick of a full bit period.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    // The edge that detected the start bit already counts as the first
    // start-bit cycle, so the mid-start decision is taken when the counter
    // reaches OVERSAMPLE/2-1 after that edge, i.e. one count earlier than
    // a plain compare would give. Every later sample then lands at
    // t0 + OVERSAMPLE/2 + k*OVERSAMPLE - 1.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Synchronised serial input.
    logic rx_s;

    uart_rx_sync #(
        .WIDTH     (1),
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk      (Div_CLK),
        .rst      (RST),
        .async_in (RX),
        .sync_out (rx_s)
    );

    uart_state_t            state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   status_q, status_d;

    // Stop-bit sampling edge, shared by the next-state and output logic.
    logic stop_sample;

    // State register: FSM, counters, shift register and registered outputs.
    always_ff @(posedge Div_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            status_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            status_q    <= status_d;
        end
    end

    // Next-state logic: frame sequencing, tick/bit counting and data shifting.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        if (En) begin
            // Disabled: drop whatever frame is in progress.
            state_d   = ST_IDLE;
            tick_d    = '0;
            bit_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    if (!rx_s) begin
                        state_d = ST_START;
                    end
                end

                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d    = '0;
                        bit_idx_d = '0;
                        // A line back high at mid-start is a glitch.
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        // LSB arrives first, so shift in from the top.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            bit_idx_d = '0;
                            state_d   = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        // Leaving mid-stop-bit lets a zero-gap next start
                        // edge be caught.
                        state_d = rx_s ? ST_IDLE : ST_BRK;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                ST_BRK: begin
                    tick_d = '0;
                    // A held-low line must return high before a new frame.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    tick_d    = '0;
                    bit_idx_d = '0;
                end
            endcase
        end
    end

    assign stop_sample = !En && (state_q == ST_STOP) && (tick_q == TICK_LAST);

    // Output logic: strobes on the stop-bit sample, DATA only from a full frame.
    always_comb begin
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        status_d    = uart_is_busy(state_d);

        if (stop_sample) begin
            if (rx_s) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign DATA      = data_q;
    assign Valid     = valid_q;
    assign Frame_Err = frame_err_q;
    assign Status_R  = status_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_receiver_enable.sv
// Bench for uart_receiver_enable: table-driven frames, hand-written corner
// sequences (glitch, break, enable abort, reset abort) and random frames.
// A scoreboard holds every expected strobe as {is_err, data, cycle}.
module tb_uart_receiver_enable;

    localparam int OS   = 16;
    localparam int DB   = 8;
    // Line change -> START entry takes 2 sync stages plus the detect edge;
    // the stop bit is then sampled OS/2 + 9*OS - 1 edges after START entry.
    localparam int ENTRY = 3;
    localparam int LAT   = ENTRY + OS / 2 + 9 * OS - 1;
    localparam int SB_W  = 1 + DB + 32;

    logic          Div_CLK;
    logic          RST;
    logic          En;
    logic          RX;
    logic [DB-1:0] DATA;
    logic          Valid;
    logic          Frame_Err;
    logic          Status_R;
    logic [2:0]    dbg_state;

    uart_receiver_enable #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .Div_CLK   (Div_CLK),
        .RST       (RST),
        .En        (En),
        .RX        (RX),
        .DATA      (DATA),
        .Valid     (Valid),
        .Frame_Err (Frame_Err),
        .Status_R  (Status_R),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial Div_CLK = 1'b0;
    always #5 Div_CLK = ~Div_CLK;

    int cyc = 0;
    always @(posedge Div_CLK) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    int status_rise = -1;
    int status_fall = -1;
    logic status_prev = 1'b0;

    always @(negedge Div_CLK) begin
        if (!RST) begin
            if (Status_R && !status_prev) status_rise = cyc;
            if (!Status_R && status_prev) status_fall = cyc;
            status_prev = Status_R;
            if (Valid || Frame_Err) begin
                logic [SB_W-1:0] act;
                logic [SB_W-1:0] exp;
                n_cmp++;
                if (Valid && Frame_Err) begin
                    n_fail++;
                    $display("FAIL strobe_overlap: Valid and Frame_Err both high at cycle %0d", cyc);
                end
                act = {Frame_Err, DATA, 32'(cyc)};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_unexpected: got err=%0b data=%02h at cycle %0d, expected none",
                             Frame_Err, DATA, cyc);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL strobe: got err=%0b data=%02h cycle=%0d, expected err=%0b data=%02h cycle=%0d",
                                 act[SB_W-1], act[SB_W-2 -: DB], act[31:0],
                                 exp[SB_W-1], exp[SB_W-2 -: DB], exp[31:0]);
                    end
                end
            end
        end else begin
            status_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        RX = v;
        repeat (n) @(posedge Div_CLK);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input int stop_len, input int gap);
        drive_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) drive_bit(b[i], OS);
        drive_bit(stop_v, stop_len);
        if (gap > 0) drive_bit(1'b1, gap);
    endtask

    // ---------------- reference model ----------------
    logic [DB-1:0] model_data = '0;

    // A frame with a high stop bit delivers its byte; a low stop bit flags
    // an error and leaves the previous good byte in place.
    task automatic model_frame(input logic [DB-1:0] b, input logic stop_v, input int start_cyc);
        if (stop_v) begin
            exp_q.push_back({1'b0, b, 32'(start_cyc + LAT)});
            model_data = b;
        end else begin
            exp_q.push_back({1'b1, model_data, 32'(start_cyc + LAT)});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DB-1:0] b;
        logic          stop_v;
        int            gap;
        logic          exp_err;
        logic [DB-1:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e;
        int rise_exp;

        vecs[0] = '{b: 8'hA5, stop_v: 1'b1, gap: 20, exp_err: 1'b0, exp_data: 8'hA5};
        vecs[1] = '{b: 8'h3C, stop_v: 1'b0, gap: 10, exp_err: 1'b1, exp_data: 8'hA5};
        vecs[2] = '{b: 8'h00, stop_v: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h00};
        vecs[3] = '{b: 8'hFF, stop_v: 1'b1, gap: 10, exp_err: 1'b0, exp_data: 8'hFF};
        vecs[4] = '{b: 8'h5A, stop_v: 1'b0, gap: 5,  exp_err: 1'b1, exp_data: 8'hFF};
        vecs[5] = '{b: 8'h81, stop_v: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h81};
        vecs[6] = '{b: 8'h7E, stop_v: 1'b1, gap: 3,  exp_err: 1'b0, exp_data: 8'h7E};

        RST = 1'b1;
        En  = 1'b0;
        RX  = 1'b1;
        repeat (3) @(posedge Div_CLK);
        #1;
        check("reset_data",     DATA,      '0);
        check("reset_valid",    Valid,     1'b0);
        check("reset_ferr",     Frame_Err, 1'b0);
        check("reset_status",   Status_R,  1'b0);
        check("reset_state",    dbg_state, 3'd0);
        RST = 1'b0;
        drive_bit(1'b1, 5);

        // Table: A5 good, 3C bad stop, 00/FF back-to-back, 5A bad, 81/7E.
        for (int k = 0; k < 7; k++) begin
            e = cyc;
            exp_q.push_back({vecs[k].exp_err, vecs[k].exp_data, 32'(e + LAT)});
            model_data = vecs[k].exp_data;
            send_frame(vecs[k].b, vecs[k].stop_v, OS, vecs[k].gap);
            if (!vecs[k].exp_err) begin
                // Status_R busy from start detect to the stop sample.
                rise_exp = (k == 3 || k == 6) ? e + ENTRY : status_rise;
                check("status_rise", status_rise, 64'(e + ENTRY));
                check("status_fall", status_fall, 64'(e + LAT));
                check("data_hold", DATA, vecs[k].exp_data);
            end
        end

        // Glitch: 4 low cycles then high aborts at mid-start sample.
        e = cyc;
        drive_bit(1'b0, 4);
        check("glitch_status_high", Status_R, 1'b1);
        drive_bit(1'b1, 20);
        check("glitch_status_low", Status_R, 1'b0);
        check("glitch_data_kept", DATA, model_data);

        // Bad stop bit with the line held low 40 cycles: stay in break.
        e = cyc;
        model_frame(8'h3C, 1'b0, e);
        drive_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) drive_bit(e[0] ? 1'b0 : 8'h3C >> i, OS);
        drive_bit(1'b0, 40);
        check("brk_status", Status_R, 1'b1);
        check("brk_state", dbg_state, 3'd4);
        check("brk_data_kept", DATA, model_data);
        drive_bit(1'b1, 20);
        check("brk_exit_status", Status_R, 1'b0);
        check("brk_exit_state", dbg_state, 3'd0);

        // En=1 at bit 3 of 0x55 aborts the frame on the next edge.
        drive_bit(1'b0, OS);
        for (int i = 0; i < 3; i++) drive_bit(((8'h55 >> i) & 1) != 0, OS);
        check("en_busy_before", Status_R, 1'b1);
        En = 1'b1;
        RX = 1'b1;
        @(posedge Div_CLK);
        #1;
        check("en_abort_status", Status_R, 1'b0);
        check("en_abort_state", dbg_state, 3'd0);
        for (int i = 3; i < DB; i++) drive_bit(((8'h55 >> i) & 1) != 0, OS);
        drive_bit(1'b1, OS + 8);
        En = 1'b0;
        drive_bit(1'b1, 4);
        e = cyc;
        model_frame(8'h55, 1'b1, e);
        send_frame(8'h55, 1'b1, OS, 6);
        check("en_clean_data", DATA, 8'h55);

        // En=1 in IDLE blocks start detection for a whole frame.
        En = 1'b1;
        drive_bit(1'b0, OS);
        check("en_idle_block", Status_R, 1'b0);
        for (int i = 0; i < DB; i++) drive_bit(1'b0, OS);
        drive_bit(1'b1, OS + 4);
        En = 1'b0;
        drive_bit(1'b1, 4);
        check("en_idle_data", DATA, 8'h55);

        // Reset at bit 5 clears everything at once; next frame is clean.
        drive_bit(1'b0, OS);
        for (int i = 0; i < 5; i++) drive_bit(((8'hC3 >> i) & 1) != 0, OS);
        check("rst_busy_before", Status_R, 1'b1);
        RST = 1'b1;
        RX  = 1'b1;
        #1;
        check("rst_mid_data",   DATA,      '0);
        check("rst_mid_valid",  Valid,     1'b0);
        check("rst_mid_ferr",   Frame_Err, 1'b0);
        check("rst_mid_status", Status_R,  1'b0);
        model_data = '0;
        @(posedge Div_CLK);
        #1;
        RST = 1'b0;
        drive_bit(1'b1, 10);
        e = cyc;
        model_frame(8'h81, 1'b1, e);
        send_frame(8'h81, 1'b1, OS, 4);
        check("rst_clean_data", DATA, 8'h81);

        // Random frames against the model, including zero-gap back-to-back.
        for (int k = 0; k < 14; k++) begin
            logic [DB-1:0] rb;
            logic          rs;
            int            rg;
            rb = DB'($urandom_range(0, 255));
            rs = ($urandom_range(0, 4) != 0);
            rg = rs ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
            e  = cyc;
            model_frame(rb, rs, e);
            send_frame(rb, rs, OS, rg);
        end
        drive_bit(1'b1, 30);
        check("rand_final_data", DATA, model_data);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
